// File: rtl/chess_turn_controller_pkg.sv
// Shared definitions for the chess turn controller.
//   - state encodings reported on the state output
//   - winner encodings reported on the winner output
//   - turn-owner encoding kept while the game is paused
//   - default full-move counter width
package chess_turn_controller_pkg;

   localparam int unsigned STATE_W    = 3;
   localparam int unsigned WIN_W      = 2;
   localparam int unsigned MOVE_W_DEF = 10;

   // Codes 5..7 are never produced and fall back to IDLE.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_P1     = 3'd1,
      ST_P2     = 3'd2,
      ST_PAUSED = 3'd3,
      ST_OVER   = 3'd4
   } state_e;

   typedef enum logic [WIN_W-1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_e;

   // Whose turn resumes when a pause is released.
   typedef enum logic {
      TURN_P1 = 1'b0,
      TURN_P2 = 1'b1
   } turn_e;

endpackage : chess_turn_controller_pkg

// File: rtl/chess_turn_controller_if.sv
// Control/status bundle between the game front panel / clock datapath and
// the turn controller.
//   master : drives start, pause, move buttons and time-expired flags,
//            observes run enables, increment pulses and game status.
//   slave  : the turn controller itself.
interface chess_turn_controller_if
   import chess_turn_controller_pkg::*;
#(
   parameter int unsigned MOVE_W = MOVE_W_DEF
);

   // Panel / datapath to controller
   logic                start;
   logic                pause;
   logic                player1_move;
   logic                player2_move;
   logic                player1_flag;
   logic                player2_flag;

   // Controller to datapath / panel
   logic                player1_run;
   logic                player2_run;
   logic                player1_add_time;
   logic                player2_add_time;
   logic                game_over;
   logic [WIN_W-1:0]    winner;
   logic [MOVE_W-1:0]   move_count;
   logic [STATE_W-1:0]  state;

   modport master (
      output start, pause, player1_move, player2_move, player1_flag, player2_flag,
      input  player1_run, player2_run, player1_add_time, player2_add_time,
             game_over, winner, move_count, state
   );

   modport slave (
      input  start, pause, player1_move, player2_move, player1_flag, player2_flag,
      output player1_run, player2_run, player1_add_time, player2_add_time,
             game_over, winner, move_count, state
   );

endinterface : chess_turn_controller_if

// File: rtl/chess_turn_controller_edge_detect.sv
// Rising-edge detector for a level input synchronous to clk.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   d_i     : level input
//   pulse_c : combinational one-cycle pulse on a 0->1 transition of d_i
// The first clock after reset only captures d_i, so a level already high
// when reset is released is not mistaken for a fresh edge.
module chess_turn_controller_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic pulse_c
);

   logic prev_q;
   logic primed_q;

   // Previous-value register plus a flag that is set after the first sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q   <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         prev_q   <= d_i;
         primed_q <= 1'b1;
      end
   end

   assign pulse_c = d_i & ~prev_q & primed_q;

endmodule : chess_turn_controller_edge_detect

// File: rtl/chess_turn_controller.sv
// Turn sequencing for a two-player chess clock.
//   clk   : system clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of chess_turn_controller_if
//           in : start, pause, player1/2_move, player1/2_flag
//           out: player1/2_run, player1/2_add_time, game_over, winner,
//                move_count, state
// Parameters:
//   MOVE_W : full-move counter width (must match the interface MOVE_W)
//   INC_EN : 1 = pulse add_time on each completed move, 0 = never pulse
// Every output is a register updated from the next-state decode, so each
// output moves exactly one clock after the input sample that causes it.
module chess_turn_controller
   import chess_turn_controller_pkg::*;
#(
   parameter int unsigned MOVE_W = MOVE_W_DEF,
   parameter bit          INC_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   chess_turn_controller_if.slave  bus
);

   localparam logic [MOVE_W-1:0] MOVE_MAX = {MOVE_W{1'b1}};

   // Registered state and outputs
   state_e             state_q,    state_d;
   turn_e              saved_q,    saved_d;
   winner_e            winner_q,   winner_d;
   logic [MOVE_W-1:0]  count_q,    count_d;
   logic               run1_q,     run1_d;
   logic               run2_q,     run2_d;
   logic               add1_q,     add1_d;
   logic               add2_q,     add2_d;
   logic               over_q,     over_d;

   // Edge pulses from the button / start inputs
   logic               start_rise_c;
   logic               p1_rise_c;
   logic               p2_rise_c;

   chess_turn_controller_edge_detect u_start_edge (
      .clk     (clk),
      .rst_n   (reset),
      .d_i     (bus.start),
      .pulse_c (start_rise_c)
   );

   chess_turn_controller_edge_detect u_p1_edge (
      .clk     (clk),
      .rst_n   (reset),
      .d_i     (bus.player1_move),
      .pulse_c (p1_rise_c)
   );

   chess_turn_controller_edge_detect u_p2_edge (
      .clk     (clk),
      .rst_n   (reset),
      .d_i     (bus.player2_move),
      .pulse_c (p2_rise_c)
   );

   // Next-state and next-output decode; turn-state priority is
   // start low > own flag > pause > own move edge.
   always_comb begin
      state_d  = state_q;
      saved_d  = saved_q;
      winner_d = winner_q;
      count_d  = count_q;
      add1_d   = 1'b0;
      add2_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_rise_c) begin
               state_d  = ST_P1;
               count_d  = '0;
               winner_d = WIN_NONE;
            end
         end

         ST_P1: begin
            if (!bus.start) begin
               state_d = ST_IDLE;
            end else if (bus.player1_flag) begin
               state_d  = ST_OVER;
               winner_d = WIN_P2;
            end else if (bus.pause) begin
               state_d = ST_PAUSED;
               saved_d = TURN_P1;
            end else if (p1_rise_c) begin
               state_d = ST_P2;
               add1_d  = INC_EN;
            end
         end

         ST_P2: begin
            if (!bus.start) begin
               state_d = ST_IDLE;
            end else if (bus.player2_flag) begin
               state_d  = ST_OVER;
               winner_d = WIN_P1;
            end else if (bus.pause) begin
               state_d = ST_PAUSED;
               saved_d = TURN_P2;
            end else if (p2_rise_c) begin
               state_d = ST_P1;
               add2_d  = INC_EN;
               // A completed full move, held at the counter ceiling.
               if (count_q != MOVE_MAX) begin
                  count_d = count_q + MOVE_W'(1);
               end
            end
         end

         ST_PAUSED: begin
            // Button edges are still tracked by the detectors but not acted on.
            if (!bus.start) begin
               state_d = ST_IDLE;
            end else if (!bus.pause) begin
               state_d = (saved_q == TURN_P2) ? ST_P2 : ST_P1;
            end
         end

         ST_OVER: begin
            if (!bus.start) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      run1_d = (state_d == ST_P1);
      run2_d = (state_d == ST_P2);
      over_d = (state_d == ST_OVER);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         saved_q  <= TURN_P1;
         winner_q <= WIN_NONE;
         count_q  <= '0;
         run1_q   <= 1'b0;
         run2_q   <= 1'b0;
         add1_q   <= 1'b0;
         add2_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         saved_q  <= saved_d;
         winner_q <= winner_d;
         count_q  <= count_d;
         run1_q   <= run1_d;
         run2_q   <= run2_d;
         add1_q   <= add1_d;
         add2_q   <= add2_d;
         over_q   <= over_d;
      end
   end

   assign bus.player1_run      = run1_q;
   assign bus.player2_run      = run2_q;
   assign bus.player1_add_time = add1_q;
   assign bus.player2_add_time = add2_q;
   assign bus.game_over        = over_q;
   assign bus.winner           = winner_q;
   assign bus.move_count       = count_q;
   assign bus.state            = state_q;

endmodule : chess_turn_controller
